button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 24 ++
 rtl/button_conditioner_if.sv | 14 +
 rtl/btn_debounce_cell.sv | 94 +++++++++
 rtl/button_conditioner.sv | 56 +++++
 tb/tb_button_conditioner.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants and helpers for the calculator front-end button conditioner.
package calc_pkg;

    localparam int unsigned N_BTN    = 9;
    localparam int unsigned BTN_ADD  = 4;
    localparam int unsigned BTN_SUB  = 5;
    localparam int unsigned BTN_MUL  = 6;
    localparam int unsigned BTN_DIV  = 7;
    localparam int unsigned BTN_SHOW = 8;

    localparam int unsigned TICK_DIV_DEF           = 100000;
    localparam int unsigned DEBOUNCE_TICKS_DEF     = 10;
    localparam int unsigned REPEAT_DELAY_TICKS_DEF = 500;
    localparam int unsigned REPEAT_RATE_TICKS_DEF  = 150;
    localparam logic [N_BTN-1:0] REPEAT_MASK_DEF   = 9'h00F;

    typedef logic [N_BTN-1:0] btn_vec_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw pushbuttons in; debounced levels, press pulses and
// the shared debounce timebase out.
interface button_conditioner_if;
    import calc_pkg::*;

    btn_vec_t buttons_raw;
    btn_vec_t btn_level;
    btn_vec_t btn_pulse;
    logic     tick;

    modport master (output buttons_raw, input btn_level, input btn_pulse, input tick);
    modport slave  (input buttons_raw, output btn_level, output btn_pulse, output tick);

endinterface

// File: rtl/btn_debounce_cell.sv
// One pushbutton: 2-flop synchronizer, tick-based debounce, press edge pulse and
// optional auto-repeat.
module btn_debounce_cell
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS     = DEBOUNCE_TICKS_DEF,
    parameter int unsigned REPEAT_DELAY_TICKS = REPEAT_DELAY_TICKS_DEF,
    parameter int unsigned REPEAT_RATE_TICKS  = REPEAT_RATE_TICKS_DEF,
    parameter bit          REPEAT_EN          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic pulse
);

    localparam int unsigned DW   = cnt_width(DEBOUNCE_TICKS);
    localparam int unsigned RMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                                   REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
    localparam int unsigned RW   = cnt_width(RMAX);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_TICKS - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_TICKS - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic          first_q, first_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_fire;

    always_comb begin
        level_d = level_q;
        deb_d   = deb_q;
        if (sync2_q == level_q) begin
            deb_d = '0;
        end else if (tick) begin
            if (deb_q == DEB_LAST) begin
                level_d = sync2_q;
                deb_d   = '0;
            end else begin
                deb_d = deb_q + DW'(1);
            end
        end
    end

    // first_q selects between the initial hold delay and the steady repeat rate.
    always_comb begin
        rep_d    = rep_q;
        first_d  = first_q;
        rep_fire = 1'b0;
        if (!REPEAT_EN || !level_q) begin
            rep_d   = '0;
            first_d = 1'b0;
        end else if (tick) begin
            if (rep_q == (first_q ? RATE_LAST : DELAY_LAST)) begin
                rep_fire = 1'b1;
                rep_d    = '0;
                first_d  = 1'b1;
            end else begin
                rep_d = rep_q + RW'(1);
            end
        end
        pulse_d = (level_d & ~level_q) | (rep_fire & level_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            first_q <= 1'b0;
            deb_q   <= '0;
            rep_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            first_q <= first_d;
            deb_q   <= deb_d;
            rep_q   <= rep_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Calculator keypad front end: shared tick prescaler feeding one debounce cell
// per button.
module button_conditioner
    import calc_pkg::*;
#(
    parameter int unsigned      TICK_DIV           = TICK_DIV_DEF,
    parameter int unsigned      DEBOUNCE_TICKS     = DEBOUNCE_TICKS_DEF,
    parameter int unsigned      REPEAT_DELAY_TICKS = REPEAT_DELAY_TICKS_DEF,
    parameter int unsigned      REPEAT_RATE_TICKS  = REPEAT_RATE_TICKS_DEF,
    parameter logic [N_BTN-1:0] REPEAT_MASK        = REPEAT_MASK_DEF
) (
    input logic                 clk,
    input logic                 reset,
    button_conditioner_if.slave bus
);

    localparam int unsigned   PW       = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;
    logic          tick_q;
    btn_vec_t      level;
    btn_vec_t      pulse;

    // Registered strobe so the first tick lands TICK_DIV cycles after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (pre_q == PRE_LAST);
            pre_q  <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_cell
        btn_debounce_cell #(
            .DEBOUNCE_TICKS     (DEBOUNCE_TICKS),
            .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
            .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS),
            .REPEAT_EN          (REPEAT_MASK[i])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.buttons_raw[i]),
            .tick  (tick_q),
            .level (level[i]),
            .pulse (pulse[i])
        );
    end

    assign bus.btn_level = level;
    assign bus.btn_pulse = pulse;
    assign bus.tick      = tick_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random presses, all
// compared against a tick-counting behavioural model.
module tb_button_conditioner;
    import calc_pkg::*;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RD = 10;
    localparam int RR = 4;
    localparam logic [N_BTN-1:0] MASK = REPEAT_MASK_DEF;

    logic clk = 1'b0;
    logic reset;

    button_conditioner_if bus_if ();

    button_conditioner #(
        .TICK_DIV           (TD),
        .DEBOUNCE_TICKS     (DB),
        .REPEAT_DELAY_TICKS (RD),
        .REPEAT_RATE_TICKS  (RR),
        .REPEAT_MASK        (MASK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: raw delay line, ticks from elapsed cycle count, per-button tick tallies.
    logic [N_BTN-1:0] m_s1, m_s2, m_level, m_pulse;
    logic             m_tick;
    int               m_n;
    int               m_dcnt [N_BTN];
    int               m_held [N_BTN];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0; m_tick = 1'b0; m_n = 0;
        for (int i = 0; i < N_BTN; i++) begin
            m_dcnt[i] = 0;
            m_held[i] = 0;
        end
    endtask

    task automatic model_step(input logic [N_BTN-1:0] r);
        logic             tick_old;
        logic             prev;
        logic [N_BTN-1:0] sync_old;
        tick_old = m_tick;
        sync_old = m_s2;
        m_s2 = m_s1;
        m_s1 = r;
        m_pulse = '0;
        for (int i = 0; i < N_BTN; i++) begin
            prev = m_level[i];
            if (sync_old[i] == m_level[i]) begin
                m_dcnt[i] = 0;
            end else if (tick_old) begin
                m_dcnt[i]++;
                if (m_dcnt[i] == DB) begin
                    m_level[i] = sync_old[i];
                    m_dcnt[i] = 0;
                end
            end
            if (!m_level[i]) begin
                m_held[i] = 0;
            end else if (!prev) begin
                m_pulse[i] = 1'b1;
                m_held[i] = 0;
            end else if (tick_old && MASK[i]) begin
                m_held[i]++;
                if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RR == 0))
                    m_pulse[i] = 1'b1;
            end
        end
        m_n++;
        m_tick = (m_n % TD == 0);
    endtask

    task automatic cycle(input logic [N_BTN-1:0] r);
        bus_if.buttons_raw = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first_tick = -1;
        reset = 1'b1;
        bus_if.buttons_raw = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_if.btn_level !== '0) begin
            errors++; $display("FAIL reset_level got=%h want=000", bus_if.btn_level);
        end
        checks++;
        if (bus_if.btn_pulse !== '0) begin
            errors++; $display("FAIL reset_pulse got=%h want=000", bus_if.btn_pulse);
        end
        checks++;
        if (bus_if.tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick got=%b want=0", bus_if.tick);
        end
        reset = 1'b0;
        model_reset();
        for (int k = 1; k <= 12; k++) begin
            cycle('0);
            if (bus_if.tick === 1'b1 && first_tick < 0) first_tick = k;
            checks++;
            if ({bus_if.btn_level, bus_if.btn_pulse, bus_if.tick} !==
                {m_level, m_pulse, m_tick}) begin
                errors++;
                $display("FAIL reset_model k=%0d got=%h/%h/%b want=%h/%h/%b", k,
                         bus_if.btn_level, bus_if.btn_pulse, bus_if.tick,
                         m_level, m_pulse, m_tick);
            end
        end
        checks++;
        if (first_tick != TD) begin
            errors++; $display("FAIL first_tick got=%0d want=%0d", first_tick, TD);
        end
    endtask

    task automatic test_press_release();
        int pulses = 0, first = -1, fall = -1;
        for (int k = 0; k < 60; k++) begin
            cycle((k < 40) ? 9'h010 : 9'h000);
            if (bus_if.btn_pulse[BTN_ADD]) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (k >= 40 && fall < 0 && bus_if.btn_level[BTN_ADD] === 1'b0) fall = k - 40;
            if (k == 39) begin
                checks++;
                if (bus_if.btn_level[BTN_ADD] !== 1'b1) begin
                    errors++; $display("FAIL press_level got=%b want=1",
                                       bus_if.btn_level[BTN_ADD]);
                end
            end
            checks++;
            if ({bus_if.btn_level, bus_if.btn_pulse, bus_if.tick} !==
                {m_level, m_pulse, m_tick}) begin
                errors++;
                $display("FAIL press_model k=%0d got=%h/%h/%b want=%h/%h/%b", k,
                         bus_if.btn_level, bus_if.btn_pulse, bus_if.tick,
                         m_level, m_pulse, m_tick);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL press_pulse_count got=%0d want=1", pulses);
        end
        checks++;
        if (first < 10 || first > 13) begin
            errors++; $display("FAIL press_latency got=%0d want=10..13", first);
        end
        checks++;
        if (fall < 10 || fall > 13) begin
            errors++; $display("FAIL release_latency got=%0d want=10..13", fall);
        end
    endtask

    task automatic test_glitch();
        int highs = 0, pulses = 0;
        for (int k = 0; k < 50; k++) begin
            cycle((k < 30 && (k / 3) % 2 == 1) ? 9'h001 : 9'h000);
            if (bus_if.btn_level[0]) highs++;
            if (bus_if.btn_pulse[0]) pulses++;
            checks++;
            if ({bus_if.btn_level, bus_if.btn_pulse, bus_if.tick} !==
                {m_level, m_pulse, m_tick}) begin
                errors++;
                $display("FAIL glitch_model k=%0d got=%h/%h/%b want=%h/%h/%b", k,
                         bus_if.btn_level, bus_if.btn_pulse, bus_if.tick,
                         m_level, m_pulse, m_tick);
            end
        end
        checks++;
        if (highs != 0 || pulses != 0) begin
            errors++;
            $display("FAIL glitch_effect got levels=%0d pulses=%0d want=0/0", highs, pulses);
        end
    endtask

    task automatic test_repeat();
        int times [16];
        int n = 0;
        for (int k = 0; k < 140; k++) begin
            cycle((k < 100) ? 9'h004 : 9'h000);
            if (bus_if.btn_pulse[2] && n < 16) begin
                times[n] = k;
                n++;
            end
            checks++;
            if ({bus_if.btn_level, bus_if.btn_pulse, bus_if.tick} !==
                {m_level, m_pulse, m_tick}) begin
                errors++;
                $display("FAIL repeat_model k=%0d got=%h/%h/%b want=%h/%h/%b", k,
                         bus_if.btn_level, bus_if.btn_pulse, bus_if.tick,
                         m_level, m_pulse, m_tick);
            end
        end
        checks++;
        if (n != 5) begin
            errors++; $display("FAIL repeat_count got=%0d want=5", n);
        end
        if (n >= 2) begin
            checks++;
            if (times[1] - times[0] != RD * TD) begin
                errors++;
                $display("FAIL repeat_first_gap got=%0d want=%0d", times[1] - times[0], RD * TD);
            end
        end
        for (int j = 2; j < n; j++) begin
            checks++;
            if (times[j] - times[j-1] != RR * TD) begin
                errors++;
                $display("FAIL repeat_gap j=%0d got=%0d want=%0d", j,
                         times[j] - times[j-1], RR * TD);
            end
        end
    endtask

    task automatic test_simultaneous();
        int f1 = -1, f6 = -1, c1 = 0, c6 = 0;
        for (int k = 0; k < 80; k++) begin
            cycle((k < 60) ? 9'h042 : 9'h000);
            if (bus_if.btn_pulse[1]) begin c1++; if (f1 < 0) f1 = k; end
            if (bus_if.btn_pulse[BTN_MUL]) begin c6++; if (f6 < 0) f6 = k; end
            checks++;
            if ({bus_if.btn_level, bus_if.btn_pulse, bus_if.tick} !==
                {m_level, m_pulse, m_tick}) begin
                errors++;
                $display("FAIL simul_model k=%0d got=%h/%h/%b want=%h/%h/%b", k,
                         bus_if.btn_level, bus_if.btn_pulse, bus_if.tick,
                         m_level, m_pulse, m_tick);
            end
        end
        checks++;
        if (f1 < 0 || f1 != f6) begin
            errors++; $display("FAIL simul_align got bit1=%0d bit6=%0d want equal", f1, f6);
        end
        checks++;
        if (c6 != 1 || c1 < 2) begin
            errors++;
            $display("FAIL simul_repeat got bit1=%0d bit6=%0d want >=2 and 1", c1, c6);
        end
    endtask

    task automatic test_reset_mid();
        int first = -1, pulses = 0;
        for (int k = 0; k < 8; k++) cycle(9'h008);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_if.btn_level, bus_if.btn_pulse, bus_if.tick} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_clear got=%h/%h/%b want=0", bus_if.btn_level,
                     bus_if.btn_pulse, bus_if.tick);
        end
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus_if.btn_pulse !== '0) begin
                errors++; $display("FAIL midreset_pulse got=%h want=000", bus_if.btn_pulse);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cycle(9'h008);
            if (bus_if.btn_pulse[3]) begin pulses++; if (first < 0) first = k; end
            checks++;
            if ({bus_if.btn_level, bus_if.btn_pulse, bus_if.tick} !==
                {m_level, m_pulse, m_tick}) begin
                errors++;
                $display("FAIL midreset_model k=%0d got=%h/%h/%b want=%h/%h/%b", k,
                         bus_if.btn_level, bus_if.btn_pulse, bus_if.tick,
                         m_level, m_pulse, m_tick);
            end
        end
        checks++;
        if (pulses != 1 || first != DB * TD) begin
            errors++;
            $display("FAIL midreset_press got n=%0d at=%0d want 1 at %0d", pulses, first, DB * TD);
        end
        // Second reset while bit 3 is accepted and its repeat counter is running.
        reset = 1'b1;
        #1;
        checks++;
        if (bus_if.btn_level !== '0) begin
            errors++; $display("FAIL repeat_reset_level got=%h want=000", bus_if.btn_level);
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle('0);
            checks++;
            if ({bus_if.btn_level, bus_if.btn_pulse, bus_if.tick} !==
                {m_level, m_pulse, m_tick}) begin
                errors++;
                $display("FAIL postreset_model k=%0d got=%h/%h/%b want=%h/%h/%b", k,
                         bus_if.btn_level, bus_if.btn_pulse, bus_if.tick,
                         m_level, m_pulse, m_tick);
            end
        end
    endtask

    task automatic test_random();
        logic [N_BTN-1:0] r;
        int hold = 0;
        int idx;
        r = '0;
        for (int k = 0; k < 2000; k++) begin
            if (hold == 0) begin
                hold = $urandom_range(24, 1);
                if ($urandom_range(3, 0) == 0) begin
                    r = N_BTN'($urandom);
                end else begin
                    idx = $urandom_range(N_BTN - 1, 0);
                    r = r ^ (N_BTN'(1) << idx);
                end
            end
            hold--;
            if ($urandom_range(249, 0) == 0) begin
                reset = 1'b1;
                #1;
                checks++;
                if ({bus_if.btn_level, bus_if.btn_pulse, bus_if.tick} !== 19'd0) begin
                    errors++;
                    $display("FAIL rand_reset k=%0d got=%h/%h/%b want=0", k,
                             bus_if.btn_level, bus_if.btn_pulse, bus_if.tick);
                end
                model_reset();
                @(negedge clk);
                reset = 1'b0;
            end
            cycle(r);
            checks++;
            if ({bus_if.btn_level, bus_if.btn_pulse, bus_if.tick} !==
                {m_level, m_pulse, m_tick}) begin
                errors++;
                $display("FAIL rand_model k=%0d raw=%h got=%h/%h/%b want=%h/%h/%b", k, r,
                         bus_if.btn_level, bus_if.btn_pulse, bus_if.tick,
                         m_level, m_pulse, m_tick);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus_if.buttons_raw = '0;
        model_reset();
        test_reset();
        test_press_release();
        test_glitch();
        test_repeat();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
